// File: rtl/coding_pkg.sv
// ============================================================================
//  Module      : coding_pkg
//  Description : Shared 8b/10b link constants, receive FSM states, encoder
//                and CRC-32 helpers for the packet receive path.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package coding_pkg;

    localparam logic [7:0]  K28_1        = 8'h3C;
    localparam logic [7:0]  K28_5        = 8'hBC;
    localparam logic [7:0]  K23_7        = 8'hF7;
    localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        SYNC = 3'd1,
        DATA = 3'd2,
        CRC  = 3'd3,
        END  = 3'd4
    } rx_state_e;

    // 5b/6b code (abcdei) as sent at negative running disparity
    function automatic logic [5:0] enc6_neg(input logic [4:0] x);
        logic [5:0] c;
        case (x)
            5'd0:  c = 6'b100111;  5'd1:  c = 6'b011101;
            5'd2:  c = 6'b101101;  5'd3:  c = 6'b110001;
            5'd4:  c = 6'b110101;  5'd5:  c = 6'b101001;
            5'd6:  c = 6'b011001;  5'd7:  c = 6'b111000;
            5'd8:  c = 6'b111001;  5'd9:  c = 6'b100101;
            5'd10: c = 6'b010101;  5'd11: c = 6'b110100;
            5'd12: c = 6'b001101;  5'd13: c = 6'b101100;
            5'd14: c = 6'b011100;  5'd15: c = 6'b010111;
            5'd16: c = 6'b011011;  5'd17: c = 6'b100011;
            5'd18: c = 6'b010011;  5'd19: c = 6'b110010;
            5'd20: c = 6'b001011;  5'd21: c = 6'b101010;
            5'd22: c = 6'b011010;  5'd23: c = 6'b111010;
            5'd24: c = 6'b110011;  5'd25: c = 6'b100110;
            5'd26: c = 6'b010110;  5'd27: c = 6'b110110;
            5'd28: c = 6'b001110;  5'd29: c = 6'b101110;
            5'd30: c = 6'b011110;  default: c = 6'b101011;
        endcase
        return c;
    endfunction

    // Full 8b/10b encode of {k, b} at running disparity rd (1 = positive)
    function automatic logic [9:0] tbeb_encode(input logic k, input logic [7:0] b, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] c6;
        logic [3:0] c4;
        logic       unb6;
        logic       rd1;
        logic       a7;
        x    = b[4:0];
        y    = b[7:5];
        c6   = (k && x == 5'd28) ? 6'b001111 : enc6_neg(x);
        unb6 = ($countones(c6) != 3);
        if (rd && (unb6 || (!k && x == 5'd7)))
            c6 = ~c6;
        rd1  = unb6 ? ~rd : rd;
        // Alternate x.7 avoids a run of five identical bits across the sub-blocks
        a7   = (!rd1 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
               ( rd1 && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        if (k && x == 5'd28) begin
            case (y)
                3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b0110;
                3'd2: c4 = 4'b1010;  3'd3: c4 = 4'b1100;
                3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b0101;
                3'd6: c4 = 4'b1001;  default: c4 = 4'b0111;
            endcase
        end else if (k) begin
            c4 = 4'b0111;
        end else begin
            case (y)
                3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;
                3'd2: c4 = 4'b0101;  3'd3: c4 = 4'b1100;
                3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;
                3'd6: c4 = 4'b0110;  default: c4 = a7 ? 4'b0111 : 4'b1110;
            endcase
        end
        if (rd1 && (k || y == 3'd0 || y == 3'd3 || y == 3'd4 || y == 3'd7))
            c4 = ~c4;
        return {c6, c4};
    endfunction

    // One byte of reflected CRC-32, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tbeb_decoder.sv
// ============================================================================
//  Module      : tbeb_decoder
//  Description : Combinational 10b -> {k, byte} decode with code validity,
//                disparity check and next running disparity.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tbeb_decoder
    import coding_pkg::*;
(
    input  logic [9:0] i_symbol,
    input  logic       i_rd,
    output logic       o_k,
    output logic [7:0] o_byte,
    output logic       o_code_err,
    output logic       o_disp_err,
    output logic       o_rd_next
);

    logic [5:0] w_six;
    logic [3:0] w_four;
    logic [3:0] w_f4;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_k28;
    logic       w_kx7;
    logic       w_k;
    logic [7:0] w_byte;
    logic [9:0] w_enc_neg;
    logic [9:0] w_enc_pos;
    logic       w_valid;
    logic [3:0] w_ones;

    function automatic logic [4:0] dec6(input logic [5:0] six);
        logic [4:0] x;
        logic [5:0] c;
        logic [5:0] alt;
        x = 5'd0;
        for (int i = 0; i < 32; i++) begin
            c   = enc6_neg(5'(i));
            alt = ($countones(c) != 3 || i == 7) ? ~c : c;
            if (six == c || six == alt)
                x = 5'(i);
        end
        return x;
    endfunction

    assign w_six  = i_symbol[9:4];
    assign w_four = i_symbol[3:0];
    assign w_k28  = (w_six == 6'b001111) || (w_six == 6'b110000);
    assign w_x    = w_k28 ? 5'd28 : dec6(w_six);
    assign w_f4   = (w_six == 6'b110000) ? ~w_four : w_four;

    always_comb begin
        w_y = 3'd0;
        if (w_k28) begin
            case (w_f4)
                4'b0100: w_y = 3'd0;
                4'b1001: w_y = 3'd1;
                4'b0101: w_y = 3'd2;
                4'b0011: w_y = 3'd3;
                4'b0010: w_y = 3'd4;
                4'b1010: w_y = 3'd5;
                4'b0110: w_y = 3'd6;
                4'b1000: w_y = 3'd7;
                default: w_y = 3'd0;
            endcase
        end else begin
            case (w_four)
                4'b1011, 4'b0100:                   w_y = 3'd0;
                4'b1001:                            w_y = 3'd1;
                4'b0101:                            w_y = 3'd2;
                4'b1100, 4'b0011:                   w_y = 3'd3;
                4'b1101, 4'b0010:                   w_y = 3'd4;
                4'b1010:                            w_y = 3'd5;
                4'b0110:                            w_y = 3'd6;
                4'b1110, 4'b0001, 4'b0111, 4'b1000: w_y = 3'd7;
                default:                            w_y = 3'd0;
            endcase
        end
    end

    assign w_kx7  = !w_k28 && (w_four == 4'b0111 || w_four == 4'b1000) &&
                    (w_x == 5'd23 || w_x == 5'd27 || w_x == 5'd29 || w_x == 5'd30);
    assign w_k    = w_k28 || w_kx7;
    assign w_byte = {w_y, w_x};

    // A symbol is legal only if re-encoding the candidate reproduces it exactly
    assign w_enc_neg = tbeb_encode(w_k, w_byte, 1'b0);
    assign w_enc_pos = tbeb_encode(w_k, w_byte, 1'b1);
    assign w_valid   = (i_symbol == w_enc_neg) || (i_symbol == w_enc_pos);
    assign w_ones    = 4'($countones(i_symbol));

    assign o_k        = w_k;
    assign o_byte     = w_byte;
    assign o_code_err = !w_valid;
    assign o_disp_err = w_valid && (i_symbol != (i_rd ? w_enc_pos : w_enc_neg));
    assign o_rd_next  = !w_valid            ? i_rd :
                        (w_ones > 4'd5)     ? 1'b1 :
                        (w_ones < 4'd5)     ? 1'b0 : i_rd;

endmodule

`default_nettype wire

// File: rtl/pkt_rx_deframer.sv
// ============================================================================
//  Module      : pkt_rx_deframer
//  Description : 8b/10b packet receiver: decodes symbols, strips sync/CRC
//                framing, forwards payload and reports CRC-32 result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pkt_rx_deframer
    import coding_pkg::*;
#(
    parameter int          SYNC_LEN    = 4,
    parameter int          MAX_PAYLOAD = 1024,
    parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pushin,
    input  logic       startin,
    input  logic [9:0] datain,
    output logic       pushout,
    output logic [7:0] dataout,
    output logic       startout,
    output logic       endout,
    output logic       crc_ok,
    output logic       frame_err,
    output logic       code_err,
    output logic       disp_err
);

    localparam int                  c_SYNC_W    = $clog2(SYNC_LEN + 1);
    localparam int                  c_LEN_W     = $clog2(MAX_PAYLOAD + 1);
    localparam logic [c_SYNC_W-1:0] c_SYNC_FULL = c_SYNC_W'(SYNC_LEN);
    localparam logic [c_LEN_W-1:0]  c_LEN_MAX   = c_LEN_W'(MAX_PAYLOAD);

    rx_state_e           r_state;
    logic                r_rd;
    logic [c_SYNC_W-1:0] r_sync_cnt;
    logic [c_LEN_W-1:0]  r_len;
    logic [1:0]          r_idx;
    logic [31:0]         r_crc;
    logic [31:0]         r_rx_crc;
    logic                r_pushout;
    logic [7:0]          r_dataout;
    logic                r_startout;
    logic                r_endout;
    logic                r_crc_ok;
    logic                r_frame_err;
    logic                r_code_err;
    logic                r_disp_err;

    logic       w_k;
    logic [7:0] w_byte;
    logic       w_code_err;
    logic       w_disp_err;
    logic       w_rd_next;
    logic       w_is_d;
    logic       w_is_k281;
    logic       w_is_k285;
    logic       w_is_k237;
    logic       w_abort;
    logic       w_sync_full;
    logic       w_unused;

    assign w_unused = startin;

    tbeb_decoder u_dec (
        .i_symbol   (datain),
        .i_rd       (r_rd),
        .o_k        (w_k),
        .o_byte     (w_byte),
        .o_code_err (w_code_err),
        .o_disp_err (w_disp_err),
        .o_rd_next  (w_rd_next)
    );

    assign w_is_d      = !w_code_err && !w_k;
    assign w_is_k281   = !w_code_err && w_k && (w_byte == K28_1);
    assign w_is_k285   = !w_code_err && w_k && (w_byte == K28_5);
    assign w_is_k237   = !w_code_err && w_k && (w_byte == K23_7);
    assign w_abort     = (r_state != HUNT) && (w_code_err || w_disp_err);
    assign w_sync_full = (r_sync_cnt == c_SYNC_FULL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= HUNT;
            r_rd        <= 1'b0;
            r_sync_cnt  <= '0;
            r_len       <= '0;
            r_idx       <= 2'd0;
            r_crc       <= CRC_INIT;
            r_rx_crc    <= 32'h0;
            r_pushout   <= 1'b0;
            r_dataout   <= 8'h00;
            r_startout  <= 1'b0;
            r_endout    <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b0;
            r_code_err  <= 1'b0;
            r_disp_err  <= 1'b0;
        end else begin
            r_pushout   <= 1'b0;
            r_startout  <= 1'b0;
            r_endout    <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b0;
            r_code_err  <= 1'b0;
            r_disp_err  <= 1'b0;
            if (pushin) begin
                r_code_err <= w_code_err;
                r_disp_err <= w_disp_err;
                r_rd       <= w_rd_next;
                if (w_abort) begin
                    r_frame_err <= 1'b1;
                    r_state     <= HUNT;
                end else begin
                    unique case (r_state)
                        HUNT: begin
                            if (w_is_k281) begin
                                r_state    <= SYNC;
                                r_sync_cnt <= c_SYNC_W'(1);
                                r_crc      <= CRC_INIT;
                            end
                        end
                        SYNC: begin
                            if (w_is_k281) begin
                                if (!w_sync_full)
                                    r_sync_cnt <= r_sync_cnt + 1'b1;
                            end else if (w_is_d && w_sync_full) begin
                                r_state    <= DATA;
                                r_pushout  <= 1'b1;
                                r_startout <= 1'b1;
                                r_dataout  <= w_byte;
                                r_crc      <= crc32_byte(r_crc, w_byte);
                                r_len      <= c_LEN_W'(1);
                            end else if (w_is_k237 && w_sync_full) begin
                                r_state <= CRC;
                                r_idx   <= 2'd0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= HUNT;
                            end
                        end
                        DATA: begin
                            if (w_is_d && r_len != c_LEN_MAX) begin
                                r_pushout <= 1'b1;
                                r_dataout <= w_byte;
                                r_crc     <= crc32_byte(r_crc, w_byte);
                                r_len     <= r_len + 1'b1;
                            end else if (w_is_k237) begin
                                r_state <= CRC;
                                r_idx   <= 2'd0;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= HUNT;
                            end
                        end
                        CRC: begin
                            if (w_is_d) begin
                                r_rx_crc[{r_idx, 3'b000} +: 8] <= w_byte;
                                r_idx <= r_idx + 2'd1;
                                if (r_idx == 2'd3)
                                    r_state <= END;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= HUNT;
                            end
                        end
                        END: begin
                            if (w_is_k285) begin
                                r_endout <= 1'b1;
                                r_crc_ok <= (r_rx_crc == ~r_crc);
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= HUNT;
                        end
                        default: r_state <= HUNT;
                    endcase
                end
            end
        end
    end

    assign pushout   = r_pushout;
    assign dataout   = r_dataout;
    assign startout  = r_startout;
    assign endout    = r_endout;
    assign crc_ok    = r_crc_ok;
    assign frame_err = r_frame_err;
    assign code_err  = r_code_err;
    assign disp_err  = r_disp_err;

endmodule

`default_nettype wire

// File: tb/tb_pkt_rx_deframer.sv
// ============================================================================
//  Module      : tb_pkt_rx_deframer
//  Description : Directed bench for pkt_rx_deframer with hand-encoded symbols.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pkt_rx_deframer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pushin = 1'b0;
    logic       startin = 1'b0;
    logic [9:0] datain = 10'h000;
    logic       pushout;
    logic [7:0] dataout;
    logic       startout;
    logic       endout;
    logic       crc_ok;
    logic       frame_err;
    logic       code_err;
    logic       disp_err;

    int total = 0;
    int bad   = 0;

    // Expected output word: {pushout, startout, endout, crc_ok, frame_err, code_err, disp_err, dataout}
    localparam logic [14:0] NO   = 15'h0000;
    localparam logic [14:0] EOK  = {4'b0011, 3'b000, 8'h00};
    localparam logic [14:0] EBAD = {4'b0010, 3'b000, 8'h00};
    localparam logic [14:0] FE   = {4'b0000, 3'b100, 8'h00};
    localparam logic [14:0] CE   = {4'b0000, 3'b010, 8'h00};
    localparam logic [14:0] DE   = {4'b0000, 3'b001, 8'h00};

    pkt_rx_deframer #(
        .SYNC_LEN    (4),
        .MAX_PAYLOAD (10),
        .CRC_INIT    (32'hFFFFFFFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pushin    (pushin),
        .startin   (startin),
        .datain    (datain),
        .pushout   (pushout),
        .dataout   (dataout),
        .startout  (startout),
        .endout    (endout),
        .crc_ok    (crc_ok),
        .frame_err (frame_err),
        .code_err  (code_err),
        .disp_err  (disp_err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] pay(input logic [7:0] b, input logic st);
        return {1'b1, st, 5'b00000, b};
    endfunction

    task automatic chk(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = {pushout, startout, endout, crc_ok, frame_err, code_err, disp_err,
               dataout & {8{exp[14]}}};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        logic [14:0] obs;
        obs = {pushout, startout, endout, crc_ok, frame_err, code_err, disp_err, dataout};
        total++;
        assert (obs === 15'h0000) else begin
            bad++;
            $error("FAIL %s observed=%h expected=0000", tag, obs);
        end
    endtask

    // Called at a negedge: drive one symbol, check its result one clock later
    task automatic sym(input logic [9:0] s, input logic [14:0] exp, input string tag);
        pushin  = 1'b1;
        datain  = s;
        startin = 1'($urandom_range(0, 1));
        @(negedge clk);
        pushin  = 1'b0;
        chk(tag, exp);
    endtask

    task automatic gap(input string tag);
        pushin = 1'b0;
        datain = 10'h3FF;
        @(negedge clk);
        chk(tag, NO);
    endtask

    task automatic send_sync(input string tag);
        sym(10'h0F9, NO, {tag, "_sync0"});
        sym(10'h306, NO, {tag, "_sync1"});
        sym(10'h0F9, NO, {tag, "_sync2"});
        sym(10'h306, NO, {tag, "_sync3"});
    endtask

    // "123456789" starting and ending at RD-
    task automatic send_payload(input string tag);
        sym(10'h239, pay(8'h31, 1'b1), {tag, "_p1"});
        sym(10'h139, pay(8'h32, 1'b0), {tag, "_p2"});
        gap({tag, "_gap"});
        sym(10'h329, pay(8'h33, 1'b0), {tag, "_p3"});
        sym(10'h0B9, pay(8'h34, 1'b0), {tag, "_p4"});
        sym(10'h2A9, pay(8'h35, 1'b0), {tag, "_p5"});
        sym(10'h1A9, pay(8'h36, 1'b0), {tag, "_p6"});
        sym(10'h3A9, pay(8'h37, 1'b0), {tag, "_p7"});
        sym(10'h0C9, pay(8'h38, 1'b0), {tag, "_p8"});
        sym(10'h269, pay(8'h39, 1'b0), {tag, "_p9"});
        sym(10'h3A8, NO, {tag, "_k237"});
    endtask

    task automatic send_good(input string tag);
        send_sync(tag);
        send_payload(tag);
        sym(10'h199, NO, {tag, "_crc0"});
        sym(10'h269, NO, {tag, "_crc1"});
        sym(10'h0B7, NO, {tag, "_crc2"});
        sym(10'h346, NO, {tag, "_crc3"});
        sym(10'h305, EOK, {tag, "_end"});
    endtask

    initial begin
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);
        chk("idle", NO);

        // 1: good packet
        send_good("t1");

        // 2: corrupted CRC byte 2 (F4 -> F5)
        send_sync("t2");
        send_payload("t2");
        sym(10'h199, NO, "t2_crc0");
        sym(10'h269, NO, "t2_crc1");
        sym(10'h2AE, NO, "t2_crc2");
        sym(10'h346, NO, "t2_crc3");
        sym(10'h305, EBAD, "t2_end");

        // 3: short sync, then a good packet
        sym(10'h0F9, NO, "t3_sync0");
        sym(10'h306, NO, "t3_sync1");
        sym(10'h0F9, NO, "t3_sync2");
        sym(10'h239, FE, "t3_short_sync");
        sym(10'h305, NO, "t3_hunt_k285");
        send_good("t3b");

        // 4: empty payload
        send_sync("t4");
        sym(10'h3A8, NO, "t4_k237");
        for (int i = 0; i < 4; i++)
            sym(10'h274, NO, "t4_crc");
        sym(10'h0FA, EOK, "t4_end");

        // 5: repeated K28.5 in DATA, then an invalid symbol in HUNT
        sym(10'h305, NO, "t5_hunt_k285");
        send_sync("t5");
        sym(10'h239, pay(8'h31, 1'b1), "t5_p1");
        sym(10'h0FA, FE, "t5_k285_in_data");
        sym(10'h0FA, DE, "t5_disp");
        sym(10'h239, NO, "t5_hunt_dcode");
        sym(10'h000, CE, "t5_code");
        sym(10'h305, NO, "t5_rd_kept");

        // Payload length limit (MAX_PAYLOAD = 10)
        send_sync("tmax");
        for (int i = 0; i < 10; i++)
            sym(10'h239, pay(8'h31, (i == 0)), "tmax_byte");
        sym(10'h239, FE, "tmax_overflow");

        // 6: reset mid-DATA at positive RD, with gaps
        send_sync("t6");
        sym(10'h239, pay(8'h31, 1'b1), "t6_p1");
        gap("t6_gap");
        sym(10'h3A9, pay(8'h37, 1'b0), "t6_p2");
        pushin = 1'b1;
        datain = 10'h329;
        #1;
        reset = 1'b0;
        #1;
        chk_zero("t6_async_reset");
        @(negedge clk);
        chk_zero("t6_reset_held");
        pushin = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        chk("t6_after_reset", NO);
        send_good("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
